// File: rtl/scan_loader_if.sv
// scan_loader_if: byte stream, scan chain and readback signals of scan_loader
//   start/abort/busy/done : pass control and status
//   in_data/in_valid/in_ready : byte stream into the loader
//   scan_in/scan_en/scan_out : memory scan chain
//   rb_data/rb_valid : bytes displaced from the chain
interface scan_loader_if;
  logic start, abort, busy, done;
  logic [7:0] in_data;
  logic in_valid, in_ready;
  logic scan_in, scan_en, scan_out;
  logic [7:0] rb_data;
  logic rb_valid;
  modport slave(
    input start, abort, in_data, in_valid, scan_out,
    output busy, done, in_ready, scan_in, scan_en, rb_data, rb_valid
  );
  modport master(
    output start, abort, in_data, in_valid, scan_out,
    input busy, done, in_ready, scan_in, scan_en, rb_data, rb_valid
  );
endinterface

// File: rtl/scan_loader.sv
// scan_loader: serialises LEN bytes MSB-first into a memory scan chain, returning displaced bytes
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : scan_loader_if.slave (control, byte stream, scan chain, readback)
module scan_loader #(
  parameter int LEN = 64
) (
  input logic clk,
  input logic reset,
  scan_loader_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] tx_sr;
  logic [6:0] rx_sr;
  logic [2:0] bit_cnt;
  logic [CW-1:0] byte_cnt;
  logic byte_end, last_byte, hs;
  assign byte_end = state == SHIFT && bit_cnt == 3'd7;
  assign last_byte = byte_cnt == LAST;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.scan_en = state == SHIFT;
  assign bus.scan_in = bus.scan_en & tx_sr[7];
  // the next byte is requested in the final shift cycle so consecutive bytes stream without a bubble
  assign bus.in_ready = state == LOAD || (byte_end && !last_byte);
  assign hs = bus.in_valid && bus.in_ready;
  always_comb begin
    state_nx = state;
    if (bus.abort) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = bus.start ? LOAD : IDLE;
        LOAD:    state_nx = hs ? SHIFT : LOAD;
        SHIFT:   state_nx = !byte_end ? SHIFT : last_byte ? DONE : hs ? SHIFT : LOAD;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_sr <= '0;
      rx_sr <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      bus.rb_data <= '0;
      bus.rb_valid <= 1'b0;
    end else begin
      bus.rb_valid <= 1'b0;
      if (bus.abort) begin
        bit_cnt <= '0;
        byte_cnt <= '0;
      end else begin
        if (state == SHIFT) begin
          tx_sr <= {tx_sr[6:0], 1'b0};
          rx_sr <= {rx_sr[5:0], bus.scan_out};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_end) begin
          byte_cnt <= byte_cnt + 1'b1;
          bus.rb_data <= {rx_sr, bus.scan_out};
          bus.rb_valid <= 1'b1;
        end
        if (hs) begin
          tx_sr <= bus.in_data;
          bit_cnt <= '0;
        end
        if (state == DONE) byte_cnt <= '0;
      end
    end
endmodule

// File: tb/tb_scan_loader.sv
// tb_scan_loader: directed passes against a bit-level memory chain and a readback scoreboard
module tb_scan_loader;
  localparam int LEN = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  scan_loader_if b();
  scan_loader #(.LEN(LEN)) dut(.clk(clk), .reset(reset), .bus(b));
  // memory chain: address a holds bits [8a+7:8a]; bits enter at bit 0 and leave from the top
  logic [8*LEN-1:0] chain = 32'hDEADBEEF;
  always @(posedge clk) if (b.scan_en) chain <= {chain[8*LEN-2:0], b.scan_in};
  assign b.scan_out = chain[8*LEN-1];
  int checks = 0, failures = 0, cyc = 0, c0 = 0;
  int shifts = 0, loadc = 0, rbn = 0, rb_base = 0;
  int accepted = 0, gap_at = -1, gap_left = 0;
  logic [7:0] q[$], exp_rb[$], rb_log[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic logic [7:0] mem(input int a);
    return chain[8*a +: 8];
  endfunction
  initial begin : feed
    logic hs;
    b.in_valid = 1'b0;
    b.in_data = 8'h00;
    forever begin
      @(negedge clk);
      hs = b.in_valid && b.in_ready;
      if (b.in_ready && gap_left > 0 && accepted == gap_at) gap_left--;
      @(posedge clk);
      #1;
      if (hs && q.size() > 0) begin
        void'(q.pop_front());
        accepted++;
      end
      b.in_valid = q.size() > 0 && !(gap_left > 0 && accepted == gap_at);
      b.in_data = q.size() > 0 ? q[0] : 8'h00;
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_in_idle_or_done", 32'(b.in_ready && (!b.busy || b.done)), 0);
      chk("scan_en_without_busy", 32'(b.scan_en && !b.busy), 0);
      if (b.scan_en) shifts++;
      if (b.busy && !b.scan_en && !b.done) loadc++;
      if (b.done) chk("rb_with_done", 32'(b.rb_valid), 1);
      if (b.rb_valid) begin
        rbn++;
        rb_log.push_back(b.rb_data);
        if (exp_rb.size() == 0) chk("rb_unexpected", 1, 0);
        else chk("rb_data", 32'(b.rb_data), 32'(exp_rb.pop_front()));
      end
    end
  end
  task automatic queue_pass(input logic [7:0] d[4]);
    for (int k = 0; k < LEN; k++) begin
      q.push_back(d[k]);
      exp_rb.push_back(mem(LEN - 1 - k));
    end
    accepted = 0;
    rb_base = rb_log.size();
  endtask
  task automatic kick;
    @(posedge clk);
    @(posedge clk);
    #2 b.start = 1'b1;
    @(posedge clk);
    #2 c0 = cyc;
    b.start = 1'b0;
  endtask
  task automatic wait_done(output int idx);
    idx = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b.done) begin
        idx = cyc - c0 + 1;
        break;
      end
    end
    if (idx < 0) chk("done_timeout", 0, 1);
  endtask
  task automatic run_pass(input logic [7:0] d[4], input int gat, input int gn, input int exp_done);
    int s0, l0, r0, didx;
    queue_pass(d);
    gap_at = gat;
    gap_left = gn;
    s0 = shifts;
    l0 = loadc;
    r0 = rbn;
    kick();
    wait_done(didx);
    chk("done_cycle", didx, exp_done);
    @(negedge clk);
    chk("busy_after_done", 32'(b.busy), 0);
    chk("shift_count", shifts - s0, 8 * LEN);
    chk("stall_cycles", loadc - l0, 1 + gn);
    chk("rb_pulses", rbn - r0, LEN);
    chk("rb_left", exp_rb.size(), 0);
    for (int k = 0; k < LEN; k++) chk("mem_final", 32'(mem(LEN - 1 - k)), 32'(d[k]));
  endtask
  task automatic chk_reset_outputs;
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_done", 32'(b.done), 0);
    chk("rst_in_ready", 32'(b.in_ready), 0);
    chk("rst_scan_in", 32'(b.scan_in), 0);
    chk("rst_scan_en", 32'(b.scan_en), 0);
    chk("rst_rb_data", 32'(b.rb_data), 0);
    chk("rst_rb_valid", 32'(b.rb_valid), 0);
  endtask
  initial begin
    int d1, d2, s0, r0, dn;
    logic [7:0] lit[4];
    b.start = 1'b0;
    b.abort = 1'b0;
    #12;
    chk_reset_outputs();
    @(posedge clk);
    #2 reset = 1'b0;
    // first pass over the initial DEADBEEF contents
    run_pass('{8'h03, 8'h02, 8'h01, 8'h00}, -1, 0, 34);
    lit = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int k = 0; k < LEN; k++) chk("lit_rb_pass1", 32'(rb_log[rb_base + k]), 32'(lit[k]));
    // five stalled cycles before byte 2
    run_pass('{8'h03, 8'h02, 8'h01, 8'h00}, 2, 5, 39);
    // start pulsed mid-pass must be ignored
    fork
      run_pass('{8'hA0, 8'hA1, 8'hA2, 8'hA3}, -1, 0, 34);
      begin
        repeat (15) @(posedge clk);
        #2 b.start = 1'b1;
        @(posedge clk);
        #2 b.start = 1'b0;
      end
    join
    lit = '{8'h03, 8'h02, 8'h01, 8'h00};
    for (int k = 0; k < LEN; k++) chk("lit_rb_pass3", 32'(rb_log[rb_base + k]), 32'(lit[k]));
    // abort in the third shift cycle of byte 1 (cycle 12)
    queue_pass('{8'hB0, 8'hB1, 8'hB2, 8'hB3});
    s0 = shifts;
    r0 = rbn;
    kick();
    repeat (12) @(negedge clk);
    chk("abort_in_shift", 32'(b.scan_en), 1);
    b.abort = 1'b1;
    @(posedge clk);
    #2 b.abort = 1'b0;
    chk("abort_busy", 32'(b.busy), 0);
    chk("abort_scan_en", 32'(b.scan_en), 0);
    chk("abort_in_ready", 32'(b.in_ready), 0);
    dn = 0;
    repeat (10) @(negedge clk) dn += int'(b.done);
    chk("abort_no_done", dn, 0);
    chk("abort_shifts", shifts - s0, 11);
    chk("abort_rb_pulses", rbn - r0, 1);
    q.delete();
    exp_rb.delete();
    run_pass('{8'hC0, 8'hC1, 8'hC2, 8'hC3}, -1, 0, 34);
    // asynchronous reset between edges in the middle of byte 2
    queue_pass('{8'hD0, 8'hD1, 8'hD2, 8'hD3});
    kick();
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outputs();
    @(posedge clk);
    #2 reset = 1'b0;
    q.delete();
    exp_rb.delete();
    @(negedge clk);
    chk("idle_after_reset", 32'(b.busy), 0);
    // back-to-back passes with start held high
    queue_pass('{8'h10, 8'h11, 8'h12, 8'h13});
    lit = '{8'h10, 8'h11, 8'h12, 8'h13};
    for (int k = 0; k < LEN; k++) begin
      q.push_back(lit[k] + 8'h10);
      exp_rb.push_back(lit[k]);
    end
    gap_left = 0;
    s0 = shifts;
    @(posedge clk);
    @(posedge clk);
    #2 b.start = 1'b1;
    @(posedge clk);
    #2 c0 = cyc;
    wait_done(d1);
    chk("b2b_done1", d1, 34);
    @(negedge clk);
    chk("b2b_gap_idle", 32'(b.busy), 0);
    @(negedge clk);
    chk("b2b_restart_busy", 32'(b.busy), 1);
    chk("b2b_restart_ready", 32'(b.in_ready), 1);
    b.start = 1'b0;
    wait_done(d2);
    chk("b2b_done2", d2, 69);
    @(negedge clk);
    chk("b2b_shifts", shifts - s0, 16 * LEN);
    chk("b2b_rb_left", exp_rb.size(), 0);
    for (int k = 0; k < LEN; k++) chk("b2b_mem", 32'(mem(LEN - 1 - k)), 32'(lit[k] + 8'h10));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_loader.md
# scan_loader

Host-side driver for the main memory's bit-serial scan chain. It accepts bytes over a valid/ready stream and serialises them MSB-first onto `scan_in`/`scan_en` so that a full pass loads all `LEN` bytes. While shifting, it captures `scan_out` and emits the displaced old memory contents as readback bytes. It sits between the test/host byte source and the memory, replacing hand-driven scan stimulus.

## Interface
Parameters:
- `LEN`, 64, number of bytes in the memory scan chain (≥2).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- `start`  in  1  begin a load pass; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE at next edge from any state.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a full pass completes.
- `in_data`  in  8  next byte to load.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted on the edge where `in_valid && in_ready`.
- `scan_in`  out  1  serial data to memory.
- `scan_en`  out  1  memory shift enable; memory shifts one bit per high cycle.
- `scan_out`  in  1  serial data from memory chain tail.
- `rb_data`  out  8  last captured readback byte.
- `rb_valid`  out  1  one-cycle pulse; `rb_data` new. No backpressure.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: `start`=1 → LOAD. `start` ignored in every other state.
- LOAD: `in_ready`=1, `scan_en`=0. Handshake → latch `in_data` into `tx_sr`, clear `bit_cnt`, → SHIFT. No handshake → stay (stall; memory holds).
- SHIFT: `scan_en`=1, `scan_in`=`tx_sr[7]`. Each cycle: `tx_sr` <<= 1, `rx_sr` <= {`rx_sr[6:0]`, `scan_out`}, `bit_cnt`++.
- On the 8th SHIFT cycle of a byte (`bit_cnt`==7):
  - `byte_cnt`++ (width clog2(LEN+1)); `rb_data` <= {`rx_sr[6:0]`, `scan_out`}; `rb_valid`=1 on the next cycle.
  - If this was byte `LEN-1` (the last byte), → DONE.
  - Else `in_ready`=1 in this same cycle. Handshake → load new byte, stay in SHIFT (zero bubble). No handshake → LOAD.
- DONE: `done`=1 for one cycle, `busy`=1, → IDLE; `byte_cnt` cleared.
- Byte order: the first byte accepted ends in memory address `LEN-1`, the last in address 0. Readback byte k (k=0..LEN-1) is the old contents of address `LEN-1-k`.
- `scan_en`, `scan_in`, `in_ready` decode from registered state/counters only; no combinational path from `in_valid` or `scan_out` to outputs.
- `abort`: → IDLE next edge; `scan_en` low from that edge; counters cleared; no `done`; a `rb_valid` pulse already scheduled still fires; the partial byte is discarded. The memory is left partially shifted, and this is accepted.
- `reset` mid-pass: same as abort but immediate and asynchronous, with all outputs at reset values.
- `abort` and `start` together in IDLE: abort wins, stay IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `in_ready`=0, `scan_in`=0, `scan_en`=0, `rb_data`=0x00, `rb_valid`=0.
- `start` sampled at edge E0 → LOAD during cycle 1 (`in_ready`=1).
- With `in_valid` held high: SHIFT in cycles 2 .. 8·LEN+1, `scan_en` continuously high for exactly 8·LEN cycles. `done` in cycle 8·LEN+2; `busy`=0 from cycle 8·LEN+3.
- Readback latency: `rb_valid` in the cycle after each byte's 8th shift cycle. The last `rb_valid` coincides with `done`.
- Each stall cycle (no handshake when a byte is due) adds exactly one cycle with `scan_en`=0.
- Total `scan_en`-high cycles per completed pass = 8·LEN, regardless of stalls.

## Test plan
- LEN=4, in_valid always high, bytes 0x03,0x02,0x01,0x00 → `scan_en` high for 32 consecutive cycles; memory[i]=i after the pass; `done` at cycle 34 after start.
- Same pass with `in_valid` dropped for 5 cycles before byte 2 → exactly 5 extra `scan_en`=0 cycles; identical final memory; `done` at cycle 39.
- Second pass loading 0xA0..0xA3 after the first → 4 `rb_valid` pulses with `rb_data`=0x03,0x02,0x01,0x00.
- `abort` asserted in the 3rd SHIFT cycle of byte 1 → IDLE next cycle, `scan_en`=0, no `done`. A new `start` then completes normally.
- `reset` pulsed mid-SHIFT (asynchronous, between edges) → all outputs at reset values immediately; `start` pulsed during a busy pass is ignored (still exactly 8·LEN shifts).
- Back-to-back passes: `start` held high → a new pass begins on the cycle after `busy` falls; `in_ready` never asserts in DONE or IDLE.
